// File: rtl/dot_product_pkg.sv
// Shared definitions for the 4-lane complex dot-product datapath.
package dot_product_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef logic [LANE_W-1:0] lane_idx_t;

  localparam lane_idx_t LAST_LANE = lane_idx_t'(NUM_LANES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
endpackage

// File: rtl/complex_lane_mux.sv
// Selects one real/imag pair out of NUM_LANES packed lanes by lane index.
module complex_lane_mux
  import dot_product_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [NUM_LANES-1:0][WIDTH-1:0] lane_re,
  input  logic [NUM_LANES-1:0][WIDTH-1:0] lane_im,
  input  lane_idx_t                       sel,
  output logic [WIDTH-1:0]                out_re,
  output logic [WIDTH-1:0]                out_im
);
  assign out_re = lane_re[sel];
  assign out_im = lane_im[sel];
endmodule

// File: rtl/complex4_serializer.sv
// Parallel-to-serial converter: one 4-lane complex vector in, four tagged
// samples out in lane order a..d, with zero-bubble back-to-back vectors.
module complex4_serializer
  import dot_product_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inaReal,
  input  logic [WIDTH-1:0] inaImag,
  input  logic [WIDTH-1:0] inbReal,
  input  logic [WIDTH-1:0] inbImag,
  input  logic [WIDTH-1:0] incReal,
  input  logic [WIDTH-1:0] incImag,
  input  logic [WIDTH-1:0] indReal,
  input  logic [WIDTH-1:0] indImag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outReal,
  output logic [WIDTH-1:0] outImag,
  output logic [1:0]       out_lane,
  output logic             out_last
);
  ser_state_t state_q, state_d;
  lane_idx_t  idx_q, idx_d;
  logic       load;
  logic       out_fire;
  logic       at_last;

  logic [NUM_LANES-1:0][WIDTH-1:0] hold_re, hold_im;

  assign at_last   = (idx_q == LAST_LANE);
  assign out_valid = (state_q == SHIFT);
  assign out_fire  = out_valid && out_ready;
  assign out_last  = out_valid && at_last;
  assign out_lane  = idx_q;
  // The last beat frees the holding register in the same cycle, so a new
  // vector can be taken on that edge without a bubble.
  assign in_ready  = !rst && ((state_q == IDLE) || (out_fire && at_last));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          load    = 1'b1;
          state_d = SHIFT;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (out_fire) begin
          if (at_last) begin
            idx_d = '0;
            if (in_valid) load = 1'b1;
            else          state_d = IDLE;
          end else begin
            idx_d = idx_q + lane_idx_t'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_re <= '0;
      hold_im <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        hold_re <= {indReal, incReal, inbReal, inaReal};
        hold_im <= {indImag, incImag, inbImag, inaImag};
      end
    end
  end

  complex_lane_mux #(.WIDTH(WIDTH)) u_mux (
    .lane_re (hold_re),
    .lane_im (hold_im),
    .sel     (idx_q),
    .out_re  (outReal),
    .out_im  (outImag)
  );
endmodule
